// File: rtl/pipe_ctrl_pkg.sv
// Package: pipe_ctrl_pkg
// Purpose: shared types and constants for the LEGv8 pipeline stall/flush
//          sequencer (pipeline_ctrl) and its hazard_detect sub-module.
// Contents:
//   pipe_state_t - sequencer state encoding (INIT, RUN, MEM_WAIT, HALT)
//   XZR          - register number of the zero register, never a real producer
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } pipe_state_t;

  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Module: hazard_detect
// Purpose: combinational load-use hazard compare between the load sitting in
//          EX (ID_EX) and the instruction being decoded in ID.
// Ports:
//   id_ra, id_rb  in  5  ID-stage source registers
//   id_uses_rb    in  1  ID instruction actually reads Rb
//   ex_memread    in  1  instruction in EX is a load
//   ex_rw         in  5  destination register of the instruction in EX
//   hazard        out 1  ID must stall one cycle behind the load
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_ra,
  input  logic [4:0] id_rb,
  input  logic       id_uses_rb,
  input  logic       ex_memread,
  input  logic [4:0] ex_rw,
  output logic       hazard
);

  logic ra_match;
  logic rb_match;

  assign ra_match = (ex_rw == id_ra);
  assign rb_match = id_uses_rb && (ex_rw == id_rb);

  // A load into XZR produces nothing to forward, so it never stalls.
  assign hazard = ex_memread && (ex_rw != XZR) && (ra_match || rb_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Module: pipeline_ctrl
// Purpose: stall/flush sequencer for the 5-stage LEGv8 pipeline. Drives the
//          PC load/select and per-register enable/flush for IF_ID, ID_EX,
//          EX_MEM and MEM_WB. Handles load-use stalls, taken-branch flushes
//          and data-memory wait; bubbles the whole pipe for INIT_CYCLES after
//          reset and halts on a memory timeout (sticky mem_err).
// Optional feature: `define PIPE_PERF_CNT_EN adds stall_cnt / flush_cnt
//          performance counters (CNT_W bits, wrapping).
// Ports:
//   clk, reset (async, active-low)
//   id_ra, id_rb, id_uses_rb, ex_memread, ex_rw  - load-use hazard inputs
//   br_taken                                     - branch taken in MEM
//   mem_req, mem_ready                           - data memory handshake
//   pc_en, pc_sel_br                             - PC control
//   *_en, *_flush                                - pipeline register control
//   mem_err                                      - sticky timeout flag
//   state_o                                      - current state
//   stall_cnt, flush_cnt                         - perf counters (optional)
// Register update rule: a register loads a bubble iff en & flush; en=0 holds.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_ra,
  input  logic [4:0]       id_rb,
  input  logic             id_uses_rb,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rw,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             pc_sel_br,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_en,
  output logic             mem_wb_flush,
  output logic             mem_err,
  output logic [1:0]       state_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

  pipe_state_t       state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;

  logic hazard;
  logic mem_stall;
  logic active;
  logic br_evt;
  logic lu_evt;

  hazard_detect u_hazard_detect (
    .id_ra      (id_ra),
    .id_rb      (id_rb),
    .id_uses_rb (id_uses_rb),
    .ex_memread (ex_memread),
    .ex_rw      (ex_rw),
    .hazard     (hazard)
  );

  // In MEM_WAIT the access is already outstanding, so only mem_ready matters;
  // once ready arrives that cycle is evaluated exactly like a RUN cycle.
  always_comb begin
    mem_stall = 1'b0;
    active    = 1'b0;
    if (state_q == RUN) begin
      mem_stall = mem_req && !mem_ready;
      active    = 1'b1;
    end else if (state_q == MEM_WAIT) begin
      mem_stall = !mem_ready;
      active    = 1'b1;
    end
  end

  assign br_evt = active && !mem_stall && br_taken;
  assign lu_evt = active && !mem_stall && !br_taken && hazard;

  always_comb begin
    pc_en        = 1'b0;
    pc_sel_br    = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_en    = 1'b0;
    mem_wb_flush = 1'b0;
    case (state_q)
      INIT: begin
        {if_id_en, id_ex_en, ex_mem_en, mem_wb_en}             = 4'b1111;
        {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = 4'b1111;
      end
      RUN, MEM_WAIT: begin
        if (mem_stall) begin
          // Freeze everything upstream; MEM_WB keeps draining bubbles so the
          // instruction waiting in MEM is not written back twice.
          mem_wb_en    = 1'b1;
          mem_wb_flush = 1'b1;
        end else if (br_evt) begin
          // Branch wins over load-use: the stalled instruction is wrong-path.
          pc_en     = 1'b1;
          pc_sel_br = 1'b1;
          {if_id_en, id_ex_en, ex_mem_en, mem_wb_en}  = 4'b1111;
          {if_id_flush, id_ex_flush, ex_mem_flush}    = 3'b111;
        end else if (lu_evt) begin
          id_ex_en    = 1'b1;
          id_ex_flush = 1'b1;
          ex_mem_en   = 1'b1;
          mem_wb_en   = 1'b1;
        end else begin
          pc_en = 1'b1;
          {if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 4'b1111;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      INIT: begin
        if (init_cnt_q == INIT_LAST) state_d = RUN;
        else                         init_cnt_d = init_cnt_q + 1'b1;
      end
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
        end else if (wait_cnt_q == WAIT_MAX) begin
          state_d   = HALT;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;
  assign state_o = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Every MEM_WAIT cycle counts as a stall, including the one where ready
  // finally arrives; load-use stalls count only when they actually win.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q == MEM_WAIT) || ((state_q == RUN) && lu_evt))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (br_evt)
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl. A stimulus process applies one input vector per
// clock and pushes the hand-computed expected outputs into a queue; a monitor
// process on the falling edge pops and compares. Output vector packing:
// {state[1:0], mem_err, pc_en, pc_sel_br,
//  if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
//  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}
module tb_pipeline_ctrl;

  localparam int CNT_W = 32;

  localparam logic [12:0] O_INIT   = {2'd0, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111};
  localparam logic [12:0] O_RUN    = {2'd1, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000};
  localparam logic [12:0] O_LU     = {2'd1, 1'b0, 1'b0, 1'b0, 4'b0111, 4'b0100};
  localparam logic [12:0] O_BR     = {2'd1, 1'b0, 1'b1, 1'b1, 4'b1111, 4'b1110};
  localparam logic [12:0] O_MS_RUN = {2'd1, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001};
  localparam logic [12:0] O_MS_WT  = {2'd2, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001};
  localparam logic [12:0] O_WT_RUN = {2'd2, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000};
  localparam logic [12:0] O_WT_BR  = {2'd2, 1'b0, 1'b1, 1'b1, 4'b1111, 4'b1110};
  localparam logic [12:0] O_HALT   = {2'd3, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] id_ra = '0, id_rb = '0, ex_rw = '0;
  logic       id_uses_rb = 1'b0, ex_memread = 1'b0, br_taken = 1'b0;
  logic       mem_req = 1'b0, mem_ready = 1'b0;
  logic       pc_en, pc_sel_br, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic       ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, mem_err;
  logic [1:0] state_o;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  typedef struct {
    logic [12:0] outs;
    bit          chk_cnt;
    int          exp_stall;
    int          exp_flush;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .INIT_CYCLES (4),
    .MEM_TIMEOUT (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_ra        (id_ra),
    .id_rb        (id_rb),
    .id_uses_rb   (id_uses_rb),
    .ex_memread   (ex_memread),
    .ex_rw        (ex_rw),
    .br_taken     (br_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .pc_sel_br    (pc_sel_br),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_en     (id_ex_en),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_en    (ex_mem_en),
    .ex_mem_flush (ex_mem_flush),
    .mem_wb_en    (mem_wb_en),
    .mem_wb_flush (mem_wb_flush),
    .mem_err      (mem_err),
    .state_o      (state_o)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  // One clock of stimulus: inputs change just after the rising edge, the
  // expected combinational outputs for that cycle go into the scoreboard.
  task automatic step(input logic rst, input logic [4:0] ra, input logic [4:0] rb,
                      input logic urb, input logic mrd, input logic [4:0] rw,
                      input logic br, input logic mreq, input logic mrdy,
                      input logic [12:0] exp_outs, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = rst;
    id_ra      = ra;
    id_rb      = rb;
    id_uses_rb = urb;
    ex_memread = mrd;
    ex_rw      = rw;
    br_taken   = br;
    mem_req    = mreq;
    mem_ready  = mrdy;
    e.outs      = exp_outs;
    e.chk_cnt   = 1'b0;
    e.exp_stall = 0;
    e.exp_flush = 0;
    e.name      = nm;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [12:0] exp_outs, input string nm);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, exp_outs, nm);
  endtask

  // Monitor: combinational outputs are present every cycle.
  initial begin
    logic [12:0] got;
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {state_o, mem_err, pc_en, pc_sel_br,
               if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
        n_checks++;
        if (got !== e.outs) begin
          n_fail++;
          $display("FAIL %s: got %b required %b", e.name, got, e.outs);
        end
`ifdef PIPE_PERF_CNT_EN
        if (e.chk_cnt) begin
          n_checks++;
          if (stall_cnt !== CNT_W'(e.exp_stall) || flush_cnt !== CNT_W'(e.exp_flush)) begin
            n_fail++;
            $display("FAIL %s counters: got stall=%0d flush=%0d required stall=%0d flush=%0d",
                     e.name, stall_cnt, flush_cnt, e.exp_stall, e.exp_flush);
          end
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal end");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held low three cycles; inputs that would otherwise act are ignored.
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_INIT, "reset_0");
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_INIT, "reset_1");
    idle(O_INIT, "reset_2_released");
    step(1'b1, 5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, O_INIT, "init_1");
    idle(O_INIT, "init_2");
    idle(O_INIT, "init_3");
    idle(O_RUN, "run_after_init");

    // Load-use on Ra, then the bubble clears it.
    step(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_LU, "lu_ra");
    idle(O_RUN, "lu_ra_cleared");
    step(1'b1, 5'd31, 5'd0, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, O_RUN, "lu_xzr");
    step(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_LU, "lu_rb");
    step(1'b1, 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_RUN, "lu_rb_unused");
    step(1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, O_RUN, "no_load");

    // Branch together with load-use: branch wins.
    step(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, O_BR, "br_over_lu");
    idle(O_RUN, "after_br");

    // Memory wait, ready on the third MEM_WAIT cycle.
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_RUN, "mem_ready_now");
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_MS_RUN, "mem_stall_run");
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, O_MS_WT, "mem_wait_1");
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_MS_WT, "mem_wait_2");
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_WT_RUN, "mem_wait_ready");
    idle(O_RUN, "back_to_run");

    // Ready arriving with a taken branch behaves like a RUN branch.
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_MS_RUN, "mem_stall_run_b");
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, O_WT_BR, "mem_ready_branch");
    idle(O_RUN, "back_to_run_b");

    // Timeout with MEM_TIMEOUT=4: four wait cycles then HALT.
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_MS_RUN, "to_stall");
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_MS_WT, $sformatf("to_wait_%0d", i + 1));
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_HALT, "halt");
    step(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, O_HALT, "halt_hold");

    // Reset pulse out of HALT.
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_INIT, "halt_reset");
    idle(O_INIT, "reinit_1");
    idle(O_INIT, "reinit_2");
    idle(O_INIT, "reinit_3");
    idle(O_INIT, "reinit_4");
    idle(O_RUN, "rerun");

    // Perf-counter sequence: 2 load-use + 3 wait cycles + 1 branch.
    step(1'b1, 5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, O_LU, "perf_lu_1");
    idle(O_RUN, "perf_gap_1");
    step(1'b1, 5'd0, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, O_LU, "perf_lu_2");
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_MS_RUN, "perf_stall");
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_MS_WT, "perf_wait_1");
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_MS_WT, "perf_wait_2");
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_WT_RUN, "perf_wait_3");
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_BR, "perf_branch");
    idle(O_RUN, "perf_final");
    exp_q[exp_q.size() - 1].chk_cnt   = 1'b1;
    exp_q[exp_q.size() - 1].exp_stall = 5;
    exp_q[exp_q.size() - 1].exp_flush = 1;

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
